// File: rtl/c7blsu_pkg.sv
// Shared encodings for the c7blsu load/store control block.
package c7blsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam int OP_UNS = 2;
  localparam int OP_ST  = 3;
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, LS1, REQ, RESP, DONE} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } op_req_t;
endpackage

// File: rtl/c7blsu_align.sv
// Combinational alignment check, store lane replication/strobes and load extraction.
module c7blsu_align
  import c7blsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]           op,
  input  logic [1:0]           addr_lo,
  input  logic [DW-1:0]        st_data,
  input  logic [DW-1:0]        ld_raw,
  output logic                 misaligned,
  output logic [DW-1:0]        st_lanes,
  output logic [NUM_LANES-1:0] st_strb,
  output logic [DW-1:0]        ld_data
);
  logic [1:0]    size;
  logic [4:0]    sh;
  logic [DW-1:0] shifted;
  logic          sgn;

  always_comb begin
    size       = op[1:0];
    misaligned = (size == SZ_H && addr_lo[0]) || (size == SZ_W && addr_lo != 2'b00) ||
                 (size == 2'd3);
    // halfwords ignore addr[0]; only addr[1] picks the half
    sh       = (size == SZ_H) ? {addr_lo[1], 4'b0000} : {addr_lo, 3'b000};
    shifted  = ld_raw >> sh;
    st_lanes = st_data;
    st_strb  = 4'b1111;
    ld_data  = ld_raw;
    sgn      = 1'b0;
    case (size)
      SZ_B: begin
        st_lanes = {NUM_LANES{st_data[7:0]}};
        st_strb  = 4'b0001 << addr_lo;
        sgn      = ~op[OP_UNS] & shifted[7];
        ld_data  = {{(DW-8){sgn}}, shifted[7:0]};
      end
      SZ_H: begin
        st_lanes = {2{st_data[15:0]}};
        st_strb  = 4'b0011 << addr_lo;
        sgn      = ~op[OP_UNS] & shifted[15];
        ld_data  = {{(DW-16){sgn}}, shifted[15:0]};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/c7blsu_ctl.sv
// Single-outstanding LSU control: E capture, LS1 align check, LS2 bus request, LS3 completion.
// Optional C7BLSU_BUSERR_EN: report bus errors alongside completion and zero load data.
module c7blsu_ctl
  import c7blsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          lsu_vld_e,
  input  logic [3:0]    lsu_op_e,
  input  logic [AW-1:0] lsu_addr_e,
  input  logic [DW-1:0] lsu_wdata_e,
  input  logic [4:0]    lsu_rd_e,
  output logic          lsu_except_ale_ls1,
  output logic [AW-1:0] lsu_badvaddr_ls1,
  output logic          lsu_ecl_data_valid_ls3,
  output logic          lsu_ecl_wr_fin_ls3,
  output logic          lsu_except_buserr_ls3,
  output logic [DW-1:0] lsu_ecl_rdata_ls3,
  output logic [4:0]    lsu_ecl_rd_ls3,
  output logic          biu_req,
  output logic          biu_we,
  output logic [AW-1:0] biu_addr,
  output logic [DW-1:0] biu_wdata,
  output logic [3:0]    biu_wstrb,
  input  logic          biu_ack,
  input  logic          biu_rvalid,
  input  logic [DW-1:0] biu_rdata,
  input  logic          biu_err
);
  state_t        state, state_nxt;
  logic [3:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q, st_lanes, ld_data;
  logic [4:0]    rd_q;
  logic [3:0]    st_strb;
  logic          misaligned, err_q;

  c7blsu_align #(.DW(DW)) u_align (
    .op(op_q), .addr_lo(addr_q[1:0]), .st_data(wdata_q), .ld_raw(rdata_q),
    .misaligned(misaligned), .st_lanes(st_lanes), .st_strb(st_strb), .ld_data(ld_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      // vld_e outside IDLE is an ECL protocol violation and is dropped
      if (state == IDLE && lsu_vld_e) begin
        op_q    <= lsu_op_e;
        addr_q  <= lsu_addr_e;
        wdata_q <= lsu_wdata_e;
        rd_q    <= lsu_rd_e;
      end
      if (state == RESP && biu_rvalid) begin
        rdata_q <= biu_rdata;
`ifdef C7BLSU_BUSERR_EN
        err_q   <= biu_err;
`else
        err_q   <= 1'b0;
`endif
      end
    end
  end

`ifndef C7BLSU_BUSERR_EN
  logic unused_err;
  assign unused_err = biu_err ^ err_q;
`endif

  always_comb begin
    state_nxt              = state;
    lsu_except_ale_ls1     = 1'b0;
    lsu_badvaddr_ls1       = '0;
    lsu_ecl_data_valid_ls3 = 1'b0;
    lsu_ecl_wr_fin_ls3     = 1'b0;
    lsu_except_buserr_ls3  = 1'b0;
    biu_req                = 1'b0;
    case (state)
      IDLE: if (lsu_vld_e) state_nxt = LS1;
      LS1: begin
        if (misaligned) begin
          lsu_except_ale_ls1 = 1'b1;
          lsu_badvaddr_ls1   = addr_q;
          state_nxt          = IDLE;
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        biu_req = 1'b1;
        if (biu_ack) state_nxt = RESP;
      end
      RESP: if (biu_rvalid) state_nxt = DONE;
      DONE: begin
        lsu_ecl_data_valid_ls3 = ~op_q[OP_ST];
        lsu_ecl_wr_fin_ls3     = op_q[OP_ST];
`ifdef C7BLSU_BUSERR_EN
        lsu_except_buserr_ls3  = err_q;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign biu_we         = op_q[OP_ST];
  assign biu_addr       = {addr_q[AW-1:2], 2'b00};
  assign biu_wdata      = st_lanes;
  assign biu_wstrb      = st_strb;
  assign lsu_ecl_rd_ls3 = rd_q;
`ifdef C7BLSU_BUSERR_EN
  assign lsu_ecl_rdata_ls3 = err_q ? '0 : ld_data;
`else
  assign lsu_ecl_rdata_ls3 = ld_data;
`endif
endmodule

// File: tb/tb_c7blsu_ctl.sv
// Scoreboard bench for c7blsu_ctl: completions are queued at issue and checked as they fire.
module tb_c7blsu_ctl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        lsu_vld_e;
  logic [3:0]  lsu_op_e;
  logic [31:0] lsu_addr_e, lsu_wdata_e;
  logic [4:0]  lsu_rd_e;
  logic        ale, dv, wf, buserr;
  logic [31:0] badvaddr, rdata_o;
  logic [4:0]  rd_o;
  logic        biu_req, biu_we, biu_ack, biu_rvalid, biu_err;
  logic [31:0] biu_addr, biu_wdata, biu_rdata;
  logic [3:0]  biu_wstrb;

  int checks = 0;
  int errors = 0;

`ifdef C7BLSU_BUSERR_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  typedef struct {
    int          kind;   // 0 load, 1 store, 2 ale
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        buserr;
    logic [31:0] badvaddr;
  } exp_t;
  exp_t sb[$];

  c7blsu_ctl dut (
    .clk(clk), .resetn(resetn), .lsu_vld_e(lsu_vld_e), .lsu_op_e(lsu_op_e),
    .lsu_addr_e(lsu_addr_e), .lsu_wdata_e(lsu_wdata_e), .lsu_rd_e(lsu_rd_e),
    .lsu_except_ale_ls1(ale), .lsu_badvaddr_ls1(badvaddr),
    .lsu_ecl_data_valid_ls3(dv), .lsu_ecl_wr_fin_ls3(wf), .lsu_except_buserr_ls3(buserr),
    .lsu_ecl_rdata_ls3(rdata_o), .lsu_ecl_rd_ls3(rd_o),
    .biu_req(biu_req), .biu_we(biu_we), .biu_addr(biu_addr), .biu_wdata(biu_wdata),
    .biu_wstrb(biu_wstrb), .biu_ack(biu_ack), .biu_rvalid(biu_rvalid),
    .biu_rdata(biu_rdata), .biu_err(biu_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic is_mis(input logic [3:0] op, input logic [31:0] a);
    case (op[1:0])
      2'd0: return 1'b0;
      2'd1: return a[0];
      2'd2: return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ld_model(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    b = (a[1:0] == 2'd0) ? r[7:0] : (a[1:0] == 2'd1) ? r[15:8] :
        (a[1:0] == 2'd2) ? r[23:16] : r[31:24];
    h = a[1] ? r[31:16] : r[15:0];
    if (op[1:0] == 2'd0) return op[2] ? {24'h0, b} : {{24{b[7]}}, b};
    if (op[1:0] == 2'd1) return op[2] ? {16'h0, h} : {{16{h[15]}}, h};
    return r;
  endfunction

  // Completion monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (int'(ale) + int'(dv) + int'(wf) > 1) begin
        errors++;
        $display("FAIL exclusive ale=%0b dv=%0b wf=%0b", ale, dv, wf);
      end
      if (ale || dv || wf || buserr) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse ale=%0b dv=%0b wf=%0b be=%0b", ale, dv, wf, buserr);
        end else begin
          e = sb.pop_front();
          if ({ale, wf, dv} !== ((e.kind == 2) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001)) begin
            errors++;
            $display("FAIL completion_kind got ale/wf/dv=%b%b%b want kind %0d", ale, wf, dv, e.kind);
          end
          if (buserr !== e.buserr) begin
            errors++;
            $display("FAIL buserr got %0b want %0b", buserr, e.buserr);
          end
          if (e.kind == 0 && (rdata_o !== e.rdata || rd_o !== e.rd)) begin
            errors++;
            $display("FAIL load_data got %h/r%0d want %h/r%0d", rdata_o, rd_o, e.rdata, e.rd);
          end
          if (e.kind == 2 && badvaddr !== e.badvaddr) begin
            errors++;
            $display("FAIL badvaddr got %h want %h", badvaddr, e.badvaddr);
          end
        end
      end
    end
  end

  // Drives vld_e for one cycle starting now; returns #1 into the LS1 cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] rresp, input logic err);
    exp_t e;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL issue_while_busy outstanding=%0d want 0", sb.size());
    end
    e.kind     = is_mis(op, a) ? 2 : (op[3] ? 1 : 0);
    e.rd       = rd;
    e.badvaddr = a;
    e.buserr   = BE && err && e.kind != 2;
    e.rdata    = e.buserr ? 32'h0 : ld_model(op, a, rresp);
    sb.push_back(e);
    lsu_vld_e = 1'b1; lsu_op_e = op; lsu_addr_e = a; lsu_wdata_e = wd; lsu_rd_e = rd;
    @(posedge clk); #1;
    lsu_vld_e = 1'b0; lsu_op_e = 4'hx; lsu_addr_e = 32'hx; lsu_wdata_e = 32'hx;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Starts in the LS1 cycle of an aligned op and walks it through REQ/RESP/DONE.
  task automatic run_bus(input logic [31:0] ea, input logic ewe, input logic [31:0] ewd,
                         input logic [3:0] estrb, input int ack_dly, input int rsp_dly,
                         input logic [31:0] rresp, input logic err);
    @(negedge clk);
    chk("ls1_req", {31'h0, biu_req}, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i <= ack_dly; i++) begin
      if (i == ack_dly) biu_ack = 1'b1;
      @(negedge clk);
      chk("req_hold", {31'h0, biu_req}, 32'h1);
      chk("req_addr", biu_addr, ea);
      chk("req_we", {31'h0, biu_we}, {31'h0, ewe});
      if (ewe) begin
        chk("req_wdata", biu_wdata, ewd);
        chk("req_wstrb", {28'h0, biu_wstrb}, {28'h0, estrb});
      end
      chk("req_no_done", {29'h0, ale, dv, wf}, 32'h0);
      @(posedge clk); #1;
      biu_ack = 1'b0;
    end
    for (int i = 0; i <= rsp_dly; i++) begin
      if (i == rsp_dly) begin biu_rvalid = 1'b1; biu_rdata = rresp; biu_err = err; end
      @(negedge clk);
      chk("resp_no_req", {31'h0, biu_req}, 32'h0);
      chk("resp_no_done", {29'h0, ale, dv, wf}, 32'h0);
      @(posedge clk); #1;
      biu_rvalid = 1'b0; biu_err = 1'b0; biu_rdata = 32'h5A5A5A5A;
    end
    @(negedge clk);
    chk("done_pulse", {30'h0, dv, wf}, ewe ? 32'h1 : 32'h2);
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    chk("done_once", {30'h0, dv, wf}, 32'h0);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", {31'h0, biu_req}, 32'h0);
    chk("rst_pulses", {28'h0, ale, dv, wf, buserr}, 32'h0);
    chk("rst_addr", biu_addr, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_lw;
    issue(4'b0010, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 1'b0);
    run_bus(32'h100, 1'b0, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_lb;
    issue(4'b0000, 32'h103, 32'h0, 5'd3, 32'h80FFFFFF, 1'b0);
    run_bus(32'h100, 1'b0, 32'h0, 4'h0, 0, 0, 32'h80FFFFFF, 1'b0);
    issue(4'b0100, 32'h103, 32'h0, 5'd4, 32'h80FFFFFF, 1'b0);
    run_bus(32'h100, 1'b0, 32'h0, 4'h0, 0, 0, 32'h80FFFFFF, 1'b0);
    issue(4'b0001, 32'h102, 32'h0, 5'd9, 32'h8001_7F00, 1'b0);
    run_bus(32'h100, 1'b0, 32'h0, 4'h0, 0, 1, 32'h8001_7F00, 1'b0);
    issue(4'b0101, 32'h100, 32'h0, 5'd10, 32'h1234_F00D, 1'b0);
    run_bus(32'h100, 1'b0, 32'h0, 4'h0, 1, 0, 32'h1234_F00D, 1'b0);
  endtask

  task automatic test_store;
    issue(4'b1001, 32'h202, 32'h1234ABCD, 5'd0, 32'h0, 1'b0);
    run_bus(32'h200, 1'b1, 32'hABCDABCD, 4'b1100, 0, 0, 32'h0, 1'b0);
    issue(4'b1000, 32'h201, 32'h000000CD, 5'd0, 32'h0, 1'b0);
    run_bus(32'h200, 1'b1, 32'hCDCDCDCD, 4'b0010, 0, 0, 32'h0, 1'b0);
    issue(4'b1010, 32'h300, 32'hCAFEF00D, 5'd0, 32'h0, 1'b0);
    run_bus(32'h300, 1'b1, 32'hCAFEF00D, 4'b1111, 0, 2, 32'h0, 1'b0);
  endtask

  // Misaligned ops fault in LS1; the second op is issued in the very next cycle.
  task automatic test_back_to_back;
    issue(4'b0010, 32'h101, 32'h0, 5'd1, 32'h0, 1'b0);
    @(negedge clk);
    chk("ale_pulse", {31'h0, ale}, 32'h1);
    chk("ale_no_req", {31'h0, biu_req}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ale_once", {31'h0, ale}, 32'h0);
    chk("ale_idle_req", {31'h0, biu_req}, 32'h0);
    issue(4'b0011, 32'h100, 32'h0, 5'd2, 32'h0, 1'b0);
    @(negedge clk);
    chk("sz3_ale", {31'h0, ale}, 32'h1);
    @(posedge clk); #1;
    issue(4'b1001, 32'h003, 32'h0000BEEF, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    chk("sh_odd_ale", {31'h0, ale}, 32'h1);
    @(posedge clk); #1;
    issue(4'b0010, 32'h040, 32'h0, 5'd31, 32'h0BADF00D, 1'b0);
    run_bus(32'h040, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0BADF00D, 1'b0);
  endtask

  task automatic test_ack_delay;
    issue(4'b0010, 32'h400, 32'h0, 5'd12, 32'h600DCAFE, 1'b0);
    run_bus(32'h400, 1'b0, 32'h0, 4'h0, 5, 3, 32'h600DCAFE, 1'b0);
  endtask

  task automatic test_reset_mid;
    issue(4'b0010, 32'h500, 32'h0, 5'd6, 32'h11111111, 1'b0);
    @(posedge clk); #1;
    biu_ack = 1'b1;
    @(posedge clk); #1;
    biu_ack = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    sb.delete();
    biu_rvalid = 1'b1; biu_rdata = 32'h11111111;
    @(negedge clk);
    chk("rstmid_req", {31'h0, biu_req}, 32'h0);
    @(posedge clk); #1;
    biu_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_no_done", {29'h0, ale, dv, wf}, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_buserr;
    issue(4'b0010, 32'h600, 32'h0, 5'd8, 32'hFFFF0000, 1'b1);
    run_bus(32'h600, 1'b0, 32'h0, 4'h0, 0, 0, 32'hFFFF0000, 1'b1);
    issue(4'b1010, 32'h604, 32'h76543210, 5'd0, 32'h0, 1'b1);
    run_bus(32'h604, 1'b1, 32'h76543210, 4'b1111, 0, 0, 32'h0, 1'b1);
  endtask

  initial begin
    lsu_vld_e = 1'b0; lsu_op_e = 4'h0; lsu_addr_e = 32'h0; lsu_wdata_e = 32'h0; lsu_rd_e = 5'h0;
    biu_ack = 1'b0; biu_rvalid = 1'b0; biu_rdata = 32'h0; biu_err = 1'b0;
    resetn = 1'b0;
    test_reset;
    test_lw;
    test_lb;
    test_store;
    test_back_to_back;
    test_ack_delay;
    test_reset_mid;
    test_buserr;
    test_lw;
    repeat (3) @(posedge clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/c7blsu_ctl.md
Name: c7blsu_ctl

Overview:
LSU-side control for single-outstanding loads and stores; the responder to the execute-stage stall controller.
- Accepts an op at E, checks alignment in LS1, issues one bus transaction in LS2, waits for the response in LS3.
- Returns exactly one completion pulse per op: ale_ls1, data_valid_ls3 or wr_fin_ls3. The ECL releases its stall on that pulse.
- Sits between the execute stage/ECL and the bus interface unit (BIU).

Parameters:
AW, 32, address width
DW, 32, data width (fixed 32; byte lanes = 4)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
lsu_vld_e  in  1  op valid at E (single-cycle pulse)
lsu_op_e  in  4  [1:0] size 0=B 1=H 2=W 3=reserved; [2] unsigned load; [3] store
lsu_addr_e  in  AW  effective address
lsu_wdata_e  in  DW  store data, right-justified
lsu_rd_e  in  5  load destination register
lsu_except_ale_ls1  out  1  misaligned-address exception pulse
lsu_badvaddr_ls1  out  AW  faulting address, valid with ale
lsu_ecl_data_valid_ls3  out  1  load complete pulse
lsu_ecl_wr_fin_ls3  out  1  store complete pulse
lsu_except_buserr_ls3  out  1  bus error pulse (see Optional Feature)
lsu_ecl_rdata_ls3  out  DW  extended load data, valid with data_valid
lsu_ecl_rd_ls3  out  5  destination register, valid with data_valid
biu_req  out  1  request; held until biu_ack
biu_we  out  1  write
biu_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
biu_wdata  out  DW  store data replicated into lanes
biu_wstrb  out  4  byte enables
biu_ack  in  1  request accepted this cycle
biu_rvalid  in  1  response valid (read data or write done)
biu_rdata  in  DW  read data
biu_err  in  1  response error

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE; all pulse outputs and biu_req = 0.
  - Data/address registers cleared to 0.
  - Reset mid-operation abandons the op; a late biu_rvalid arriving in IDLE is ignored.
- FSM IDLE -> LS1 -> REQ -> RESP -> DONE -> IDLE. The op (op, addr, wdata, rd) is captured on lsu_vld_e in IDLE.
- LS1 (one cycle):
  - Misaligned if H with addr[0]=1, W with addr[1:0]!=0, or size=3.
  - Misaligned: assert ale_ls1 and badvaddr_ls1 for this cycle only, -> IDLE, no bus activity.
  - Aligned: -> REQ.
- REQ: biu_req=1; addr, we, wdata and wstrb stable until biu_ack. -> RESP on ack.
- RESP: wait for biu_rvalid; capture rdata and err. -> DONE.
- DONE (one cycle):
  - Load: data_valid_ls3=1 with extended rdata and rd.
  - Store: wr_fin_ls3=1.
- Minimum latency: vld_e at cycle 0, ale at cycle 1, or ack at cycle 2 with rvalid at cycle 3 giving the completion pulse at cycle 4.
- Load extraction, lane = addr[1:0]:
  - B selects byte lane; H selects halfword addr[1].
  - Sign-extend unless op[2]=1, then zero-extend.
- Store lanes:
  - B: wdata[7:0] x4, wstrb = 1<<addr[1:0].
  - H: wdata[15:0] x2, wstrb = 4'b0011<<addr[1:0].
  - W: wstrb = 4'b1111.
- Completion outputs are mutually exclusive; exactly one fires per accepted op.
- lsu_vld_e outside IDLE is a protocol violation (ECL stalls issue). Block ignores it; bench asserts it never happens.
- biu_ack and biu_rvalid in the same cycle during REQ: illegal (BIU responds no earlier than the cycle after ack).

Optional Feature:
C7BLSU_BUSERR_EN
- Defined:
  - rvalid with err makes DONE assert lsu_except_buserr_ls3 together with the normal data_valid_ls3 or wr_fin_ls3, so the ECL stall still releases.
  - lsu_ecl_rdata_ls3 is forced to 0.
- Undefined: biu_err ignored, lsu_except_buserr_ls3 tied 0, rdata passed through.

Decomposition:
- Package c7blsu_pkg holds:
  - size encodings (SZ_B/SZ_H/SZ_W);
  - op bit positions (OP_UNS=2, OP_ST=3);
  - FSM state enum (IDLE, LS1, REQ, RESP, DONE).
- One combinational sub-module, c7blsu_align:
  - alignment check;
  - store lane/strobe formation;
  - load byte extraction and extension.
- FSM and registers stay in c7blsu_ctl.

Test Plan:
1. LW addr 0x100, ack cycle 2, rvalid cycle 3, rdata 0xDEADBEEF -> data_valid at cycle 4, rdata 0xDEADBEEF, rd echoed.
2. LB addr 0x103, rdata 0x80FFFFFF -> 0xFFFFFF80; LBU same -> 0x00000080.
3. SH addr 0x202, wdata 0x1234ABCD -> biu_addr 0x200, wdata 0xABCDABCD, wstrb 4'b1100, we=1; rvalid -> wr_fin one cycle.
4. LW addr 0x101 -> ale_ls1 at cycle 1, badvaddr 0x101, biu_req never asserted, FSM back in IDLE at cycle 2.
5. biu_ack delayed 5 cycles -> req and address stable throughout; no completion pulse before rvalid.
6. resetn low while in RESP, then rvalid arrives -> no completion pulse. With C7BLSU_BUSERR_EN, an LW with err=1 -> buserr_ls3=1, data_valid_ls3=1, rdata=0.
